uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_arb_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner selection for the UART TX arbiter.
// Searches the requesters starting at the one named by ptr. The first valid
// one wins and is returned one-hot. With ptr held at zero this reduces to
// fixed priority, where requester 0 wins.
module uart_arb_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner
);

    logic [PTR_W-1:0] idx;

    // Rotating search; the lowest offset from ptr that is valid is kept last and wins
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (valid[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART TX arbiter: grants one of NREQ requesters a 32-bit word slot. It then
// feeds the top BYTES_PER_WORD bytes, MSB first, to a byte-wide UART sender.
// Optional feature: define UART_TX_ARB_RR_EN for round-robin tie breaking.
// Without that macro, requester 0 always wins ties and there is no pointer state.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int NREQ           = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_data,
    output logic [NREQ-1:0]              req_ack,
    output logic [NREQ-1:0]              grant,
    output logic                         busy,
    output logic [BYTE_W-1:0]            sender_data,
    output logic                         sender_enable,
    input  logic                         sender_ready
);

    localparam int         PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] CNT_LAST = 2'(BYTES_PER_WORD - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [WORD_W-1:0] shift;
    logic [1:0]        count;
    logic [NREQ-1:0]   pick;
    logic [WORD_W-1:0] pick_data;
    logic [PTR_W-1:0]  ptr;

`ifdef UART_TX_ARB_RR_EN
    // Pointer value after a transaction: the requester following the one just served
    function automatic logic [PTR_W-1:0] ptr_after(input logic [NREQ-1:0] owner);
        ptr_after = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner[i]) ptr_after = PTR_W'((i + 1) % NREQ);
        end
    endfunction
`else
    assign ptr = '0;
`endif

    uart_arb_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .winner (pick)
    );

    // Route the winning requester's word to the shift register load path
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_data = req_data[i];
        end
    end

    // Next-state logic: a byte handshake is SEND until the sender goes busy, then BUSY until it is idle again
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid)    state_nxt = SEND;
            SEND:    if (!sender_ready) state_nxt = BUSY;
            BUSY:    if (sender_ready)  state_nxt = (count == CNT_LAST) ? DONE : SEND;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State, word shift register, byte counter, grant and pointer; the word is captured only at grant
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            shift <= '0;
            count <= '0;
            grant <= '0;
`ifdef UART_TX_ARB_RR_EN
            ptr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        shift <= pick_data;
                        count <= '0;
                        grant <= pick;
                    end
                end
                BUSY: begin
                    if (sender_ready && (count != CNT_LAST)) begin
                        shift <= {shift[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        count <= count + 2'd1;
                    end
                end
                DONE: begin
                    grant <= '0;
`ifdef UART_TX_ARB_RR_EN
                    ptr   <= ptr_after(grant);
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state, so reset forces them low without a clock edge
    always_comb begin
        busy          = (state != IDLE);
        sender_enable = (state == SEND);
        sender_data   = (state == SEND) ? shift[WORD_W-1 -: BYTE_W] : '0;
        req_ack       = (state == DONE) ? grant : '0;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. The main instance uses 4 bytes per word and
// the second instance uses 1. The expected byte and ack stream comes from a
// queue-based arbitration model. The optional feature is UART_TX_ARB_RR_EN.
module tb_uart_tx_arbiter;

    localparam int B_DLY = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0]        req_valid = '0;
    logic [1:0][31:0]  req_data  = '0;
    logic [1:0]        req_ack;
    logic [1:0]        grant;
    logic              busy;
    logic [7:0]        sender_data;
    logic              sender_enable;
    logic              sender_ready = 1'b1;

    logic [1:0]        b_valid = '0;
    logic [1:0][31:0]  b_data  = '0;
    logic [1:0]        b_ack;
    logic [1:0]        b_grant;
    logic              b_busy;
    logic [7:0]        b_sdata;
    logic              b_sen;
    logic              b_ready = 1'b1;

    uart_tx_arbiter #(.BYTES_PER_WORD(4), .NREQ(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .grant(grant), .busy(busy), .sender_data(sender_data),
        .sender_enable(sender_enable), .sender_ready(sender_ready)
    );

    uart_tx_arbiter #(.BYTES_PER_WORD(1), .NREQ(2)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .req_valid(b_valid), .req_data(b_data),
        .req_ack(b_ack), .grant(b_grant), .busy(b_busy), .sender_data(b_sdata),
        .sender_enable(b_sen), .sender_ready(b_ready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int log_a[$];
    int log_b[$];
    int exp_q[$];
    int gaps[$];
    int last_ack_cyc = -100;
    int b_byte_cyc = 0;
    int b_ack_cyc = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] m0[$];
    logic [31:0] m1[$];
    bit   drv_on = 1'b0;
    bit   stall = 1'b0;
    int   corrupt_mode = 0;
    int   delay = 10;
    int   a_cnt = 0;
    int   b_cnt = 0;
    logic [1:0] grant_prev = '0;
`ifdef UART_TX_ARB_RR_EN
    int m_ptr = 0;
`endif

    // Sender models, event monitors and requester drivers, all on the falling edge
    always @(negedge CLK) begin
        cyc++;
        if (!RST_N) begin
            sender_ready = 1'b1;
            a_cnt = 0;
        end else if (!sender_ready) begin
            a_cnt--;
            if (a_cnt <= 0) sender_ready = 1'b1;
        end else if (sender_enable && !stall) begin
            log_a.push_back(int'(sender_data));
            sender_ready = 1'b0;
            a_cnt = delay;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_ack[i]) begin
                log_a.push_back(256 + i);
                last_ack_cyc = cyc;
            end
        end
        if (grant != 2'b00 && grant_prev == 2'b00) gaps.push_back(cyc - last_ack_cyc);
        n_checks++;
        if (busy !== (grant != 2'b00) || $countones(grant) > 1) begin
            n_errors++;
            $display("FAIL busy_grant: busy=%b grant=%b, required busy equal to |grant and grant one-hot", busy, grant);
        end
        if (drv_on) begin
            if (req_ack[0]) begin
                void'(q0.pop_front());
                req_valid[0] = (q0.size() > 0);
                if (q0.size() > 0) req_data[0] = q0[0];
            end else if (grant[0] && !grant_prev[0]) begin
                if (corrupt_mode == 1) req_data[0] = 32'h0;
                else if (corrupt_mode == 2) begin
                    req_data[0] = $urandom;
                    if ($urandom_range(0, 1) == 1) req_valid[0] = 1'b0;
                end
            end
            if (req_ack[1]) begin
                void'(q1.pop_front());
                req_valid[1] = (q1.size() > 0);
                if (q1.size() > 0) req_data[1] = q1[0];
            end else if (grant[1] && !grant_prev[1]) begin
                if (corrupt_mode == 1) req_data[1] = 32'h0;
                else if (corrupt_mode == 2) begin
                    req_data[1] = $urandom;
                    if ($urandom_range(0, 1) == 1) req_valid[1] = 1'b0;
                end
            end
        end
        grant_prev = grant;
        if (!RST_N) begin
            b_ready = 1'b1;
            b_cnt = 0;
        end else if (!b_ready) begin
            b_cnt--;
            if (b_cnt <= 0) b_ready = 1'b1;
        end else if (b_sen) begin
            log_b.push_back(int'(b_sdata));
            b_byte_cyc = cyc;
            b_ready = 1'b0;
            b_cnt = B_DLY;
        end
        for (int i = 0; i < 2; i++) begin
            if (b_ack[i]) begin
                log_b.push_back(256 + i);
                b_ack_cyc = cyc;
                b_valid[i] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // Reference model: serve words by the tie rule and expand each into its 4 bytes plus an ack marker
    task automatic model_run();
        int i0;
        int i1;
        int win;
        logic [31:0] w;
        i0 = 0;
        i1 = 0;
        exp_q.delete();
        while (i0 < m0.size() || i1 < m1.size()) begin
            if (i0 < m0.size() && i1 < m1.size()) begin
`ifdef UART_TX_ARB_RR_EN
                win = m_ptr;
`else
                win = 0;
`endif
            end else begin
                win = (i0 < m0.size()) ? 0 : 1;
            end
            if (win == 0) begin w = m0[i0]; i0++; end
            else          begin w = m1[i1]; i1++; end
            for (int b = 0; b < 4; b++) exp_q.push_back(int'((w >> (24 - 8 * b)) & 32'hFF));
            exp_q.push_back(256 + win);
`ifdef UART_TX_ARB_RR_EN
            m_ptr = 1 - win;
`endif
        end
    endtask

    task automatic start_words();
        @(negedge CLK);
        m0 = q0;
        m1 = q1;
        model_run();
        log_a.delete();
        gaps.delete();
        req_valid[0] = (q0.size() > 0);
        if (q0.size() > 0) req_data[0] = q0[0];
        req_valid[1] = (q1.size() > 0);
        if (q1.size() > 0) req_data[1] = q1[0];
        drv_on = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            if (q0.size() == 0 && q1.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_grant: got %b, required 00", grant); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if (req_ack !== 2'b00) begin n_errors++; $display("FAIL rst_ack: got %b, required 00", req_ack); end
        n_checks++; if (sender_enable !== 1'b0) begin n_errors++; $display("FAIL rst_enable: got %b, required 0", sender_enable); end
        n_checks++; if (sender_data !== 8'h00) begin n_errors++; $display("FAIL rst_data: got %h, required 00", sender_data); end
        n_checks++; if (b_grant !== 2'b00 || b_busy !== 1'b0) begin n_errors++; $display("FAIL rst_b: grant=%b busy=%b, required 00/0", b_grant, b_busy); end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || sender_enable !== 1'b0) begin n_errors++; $display("FAIL rst_release_idle: busy=%b en=%b, required 0/0", busy, sender_enable); end
    endtask

    task automatic test_single();
        bit ok;
        delay = 10;
        corrupt_mode = 0;
        q0.delete(); q1.delete();
        q0.push_back(32'hDEADBEEF);
        start_words();
        wait_idle(1000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL single_done: timed out with busy=%b, required idle", busy); end
        n_checks++; if (log_a.size() != exp_q.size()) begin n_errors++; $display("FAIL single_len: got %0d events, required %0d", log_a.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < log_a.size(); k++) begin
            n_checks++; if (log_a[k] !== exp_q[k]) begin n_errors++; $display("FAIL single_ev%0d: got %0h, required %0h", k, log_a[k], exp_q[k]); end
        end
    endtask

    task automatic test_data_change();
        bit ok;
        delay = $urandom_range(1, 6);
        corrupt_mode = 1;
        q0.delete(); q1.delete();
        q0.push_back($urandom | 32'h0100_0000);
        start_words();
        wait_idle(1000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL chg_done: timed out with busy=%b, required idle", busy); end
        n_checks++; if (log_a.size() != exp_q.size()) begin n_errors++; $display("FAIL chg_len: got %0d events, required %0d", log_a.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < log_a.size(); k++) begin
            n_checks++; if (log_a[k] !== exp_q[k]) begin n_errors++; $display("FAIL chg_ev%0d: got %0h, required %0h", k, log_a[k], exp_q[k]); end
        end
    endtask

    task automatic test_tie_random();
        bit ok;
        int n0;
        int n1;
        for (int it = 0; it < 4; it++) begin
            n0 = (it == 0) ? 3 : int'($urandom_range(1, 3));
            n1 = (it == 0) ? 3 : int'($urandom_range(1, 3));
            delay = (it == 0) ? 10 : int'($urandom_range(1, 6));
            corrupt_mode = (it == 0) ? 0 : 2;
            q0.delete(); q1.delete();
            for (int k = 0; k < n0; k++) q0.push_back($urandom);
            for (int k = 0; k < n1; k++) q1.push_back($urandom);
            start_words();
            wait_idle(3000, ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL tie%0d_done: timed out with busy=%b, required idle", it, busy); end
            n_checks++; if (log_a.size() != exp_q.size()) begin n_errors++; $display("FAIL tie%0d_len: got %0d events, required %0d", it, log_a.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < log_a.size(); k++) begin
                n_checks++; if (log_a[k] !== exp_q[k]) begin n_errors++; $display("FAIL tie%0d_ev%0d: got %0h, required %0h", it, k, log_a[k], exp_q[k]); end
            end
            for (int k = 1; k < gaps.size(); k++) begin
                n_checks++; if (gaps[k] !== 2) begin n_errors++; $display("FAIL tie%0d_gap%0d: grant came %0d cycles after ack, required 2", it, k, gaps[k]); end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        int bad;
        logic [31:0] w;
        delay = 4;
        corrupt_mode = 0;
        stall = 1'b1;
        w = $urandom;
        q0.delete(); q1.delete();
        q0.push_back(w);
        start_words();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            seen = sender_enable;
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL stall_enter: sender_enable=%b, required 1", sender_enable); end
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (sender_enable !== 1'b1 || sender_data !== w[31:24] || req_ack !== 2'b00) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL stall_hold: %0d cycles left SEND or changed byte, required 0 (byte %h)", bad, w[31:24]); end
        stall = 1'b0;
        wait_idle(1000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_done: timed out with busy=%b, required idle", busy); end
        n_checks++; if (log_a.size() != exp_q.size()) begin n_errors++; $display("FAIL stall_len: got %0d events, required %0d", log_a.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < log_a.size(); k++) begin
            n_checks++; if (log_a[k] !== exp_q[k]) begin n_errors++; $display("FAIL stall_ev%0d: got %0h, required %0h", k, log_a[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        delay = 10;
        corrupt_mode = 0;
        q0.delete(); q1.delete();
        q0.push_back(32'h01020304);
        start_words();
        exp_q.push_front(2);
        exp_q.push_front(1);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge CLK);
            hit = (log_a.size() == 2) && busy && !sender_enable;
        end
        n_checks++; if (!hit) begin n_errors++; $display("FAIL rmid_reach: bytes=%0d busy=%b, required 2 bytes in BUSY", log_a.size(), busy); end
        RST_N = 1'b0;
        #1;
        n_checks++; if (sender_enable !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || req_ack !== 2'b00) begin
            n_errors++; $display("FAIL rmid_async: en=%b grant=%b busy=%b ack=%b, required all 0", sender_enable, grant, busy, req_ack);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_idle(1000, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rmid_done: timed out with busy=%b, required idle", busy); end
        n_checks++; if (log_a.size() != exp_q.size()) begin n_errors++; $display("FAIL rmid_len: got %0d events, required %0d", log_a.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < log_a.size(); k++) begin
            n_checks++; if (log_a[k] !== exp_q[k]) begin n_errors++; $display("FAIL rmid_ev%0d: got %0h, required %0h", k, log_a[k], exp_q[k]); end
        end
    endtask

    task automatic test_bpw1();
        bit ok;
        int r;
        logic [31:0] w;
        for (int it = 0; it < 2; it++) begin
            r = it;
            w = (it == 0) ? {8'hA5, 24'($urandom)} : $urandom;
            @(negedge CLK);
            log_b.delete();
            b_data[r] = w;
            b_valid[r] = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge CLK);
                ok = (log_b.size() >= 2) && !b_busy;
            end
            n_checks++; if (!ok) begin n_errors++; $display("FAIL b%0d_done: events=%0d busy=%b, required byte+ack then idle", it, log_b.size(), b_busy); end
            n_checks++; if (log_b.size() != 2) begin n_errors++; $display("FAIL b%0d_len: got %0d events, required 2", it, log_b.size()); end
            if (log_b.size() >= 2) begin
                n_checks++; if (log_b[0] !== int'(w[31:24])) begin n_errors++; $display("FAIL b%0d_byte: got %0h, required %0h", it, log_b[0], w[31:24]); end
                n_checks++; if (log_b[1] !== 256 + r) begin n_errors++; $display("FAIL b%0d_ack: got %0h, required %0h", it, log_b[1], 256 + r); end
                n_checks++; if (b_ack_cyc - b_byte_cyc !== B_DLY + 1) begin n_errors++; $display("FAIL b%0d_ack_lat: got %0d cycles, required %0d", it, b_ack_cyc - b_byte_cyc, B_DLY + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_random();
        test_single();
        test_data_change();
        test_stall();
        test_reset_mid();
        test_bpw1();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
